// File: rtl/subbytes_seq.sv
// Iterative AES SubBytes: four S-boxes substitute one 32-bit column per cycle over four cycles.
// Optional inverse S-box path is compiled in when SUBBYTES_INV_EN is defined.
module subbytes_seq (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         dec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int unsigned STATE_W = 128;
  localparam int unsigned COL_W   = 32;
  localparam int unsigned NCOL    = 4;
  localparam int unsigned BYTE_W  = 8;

  // FIPS-197 forward S-box, entry 0x00 in the most significant byte
  localparam logic [2047:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [BYTE_W-1:0] sbox_fwd(input logic [BYTE_W-1:0] x);
    logic [10:0] base;
    base = {~x, 3'b000};
    return SBOX_FWD[base +: BYTE_W];
  endfunction

`ifdef SUBBYTES_INV_EN
  localparam logic [2047:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [BYTE_W-1:0] sbox_inv(input logic [BYTE_W-1:0] x);
    logic [10:0] base;
    base = {~x, 3'b000};
    return SBOX_INV[base +: BYTE_W];
  endfunction
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           col_q, col_d;
  logic [STATE_W-1:0]   work_q, work_d;
  logic [STATE_W-1:0]   out_q, out_d;
  logic                 load;
  logic [6:0]           col_base;
  logic [COL_W-1:0]     col_in;
  logic [COL_W-1:0]     col_out;

  // Column col occupies bits [127-32*col -: 32], i.e. offset (3-col)*32
  assign col_base = {~col_q, 5'b00000};
  assign col_in   = work_q[col_base +: COL_W];

`ifdef SUBBYTES_INV_EN
  logic dec_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dec_q <= 1'b0;
    end else if (load) begin
      dec_q <= dec;
    end
  end

  for (genvar i = 0; i < NCOL; i++) begin : g_sbox
    assign col_out[i*BYTE_W +: BYTE_W] = dec_q ? sbox_inv(col_in[i*BYTE_W +: BYTE_W])
                                               : sbox_fwd(col_in[i*BYTE_W +: BYTE_W]);
  end
`else
  logic unused_dec;
  assign unused_dec = dec;

  for (genvar i = 0; i < NCOL; i++) begin : g_sbox
    assign col_out[i*BYTE_W +: BYTE_W] = sbox_fwd(col_in[i*BYTE_W +: BYTE_W]);
  end
`endif

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      work_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      work_q  <= work_d;
      out_q   <= out_d;
    end
  end

  // Next-state, datapath update and input handshake
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    work_d   = work_q;
    out_d    = out_q;
    in_ready = 1'b0;
    load     = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) load = 1'b1;
      end
      SUB: begin
        work_d[col_base +: COL_W] = col_out;
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) begin
          state_d = DONE;
          out_d   = work_d;
        end
      end
      DONE: begin
        // Result is held until taken; a new block can enter on the same edge
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) load = 1'b1;
          else          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      work_d  = in_state;
      col_d   = 2'd0;
      state_d = SUB;
    end
  end

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == SUB);
  assign out_state = out_q;

endmodule

// File: tb/tb_subbytes_seq.sv
// Scoreboard bench for subbytes_seq: directed FIPS-197 vectors, backpressure, back-to-back and reset.
module tb_subbytes_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_state = '0;
  logic         dec = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_state;
  logic         busy;

  subbytes_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .dec       (dec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [127:0] exp_q[$];
  int           pop_cyc[$];

  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
`ifdef SUBBYTES_INV_EN
  localparam logic [127:0] INV_EXP  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
`else
  localparam logic [127:0] INV_EXP  = 128'h48cc82e4e10846a16c8d4cd972830004;
`endif

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  // Monitor: every completed output handshake is checked against the queue head
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: actual %h required no output", out_state);
        end else begin
          check("out_state", out_state, exp_q.pop_front());
          pop_cyc.push_back(cyc);
        end
      end
    end
  end

  // Offer a state, wait for acceptance; waits = number of negedges until in_ready seen
  task automatic send(input logic [127:0] s, input logic d, input bit track,
                      input logic [127:0] req, output int waits);
    bit ok;
    ok = 1'b0;
    waits = 0;
    in_valid = 1'b1;
    in_state = s;
    dec = d;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      waits++;
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept_timeout", 128'(ok), 128'(1'b1));
    if (track) exp_q.push_back(req);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_state = {$urandom, $urandom, $urandom, $urandom};
    dec = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    for (int n = 0; n < 100; n++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain_empty", 128'(exp_q.size()), 128'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int busy_cnt;
    int lat;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 128'(out_valid), 128'(1'b0));
    check("reset_busy",      128'(busy),      128'(1'b0));
    check("reset_out_state", out_state,       128'h0);
    check("reset_in_ready",  128'(in_ready),  128'(1'b1));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    // FIPS-197 round 1 SubBytes, latency and busy window
    send(FIPS_IN, 1'b0, 1'b1, FIPS_OUT, w);
    busy_cnt = 0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    check("fips_latency",     128'(lat),      128'(5));
    check("fips_busy_cycles", 128'(busy_cnt), 128'(4));
    drain();

    // Inverse request (forward image when the inverse path is not built)
    send(FIPS_OUT, 1'b1, 1'b1, INV_EXP, w);
    drain();

    // Back-to-back with out_ready held high
    pop_cyc.delete();
    send({16{8'h00}}, 1'b0, 1'b1, {16{8'h63}}, w);
    send({16{8'h53}}, 1'b0, 1'b1, {16{8'hed}}, w);
    send({16{8'hff}}, 1'b0, 1'b1, {16{8'h16}}, w);
    drain();
    check("b2b_count", 128'(pop_cyc.size()), 128'(3));
    for (int i = 1; i < pop_cyc.size(); i++)
      check("b2b_spacing", 128'(pop_cyc[i] - pop_cyc[i-1]), 128'(5));

    // Backpressure: result held, second offer refused until out_ready
    out_ready = 1'b0;
    send({16{8'h00}}, 1'b0, 1'b1, {16{8'h63}}, w);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    in_valid = 1'b1;
    in_state = {16{8'hff}};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("hold_out_valid", 128'(out_valid), 128'(1'b1));
      check("hold_in_ready",  128'(in_ready),  128'(1'b0));
      check("hold_busy",      128'(busy),      128'(1'b0));
      check("hold_out_state", out_state,       {16{8'h63}});
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send({16{8'hff}}, 1'b0, 1'b1, {16{8'h16}}, w);
    check("release_same_cycle", 128'(w), 128'(1));
    drain();

    // Reset asserted at T2 of a block
    send({16{8'h53}}, 1'b0, 1'b0, '0, w);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", 128'(out_valid), 128'(1'b0));
    check("midrst_busy",      128'(busy),      128'(1'b0));
    check("midrst_out_state", out_state,       128'h0);
    check("midrst_in_ready",  128'(in_ready),  128'(1'b1));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 128'(in_ready), 128'(1'b1));
    repeat (8) @(negedge clk);
    check("post_rst_no_valid", 128'(out_valid), 128'(1'b0));
    @(posedge clk);
    #1;
    send({16{8'h00}}, 1'b0, 1'b1, {16{8'h63}}, w);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
